// File: rtl/bus_timer_responder_if.sv
// CPU-side bus between the core and the timer responder: address/strobe/write data
// in, registered read data and a level interrupt back.
interface bus_timer_responder_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] address_i;
   logic                  we_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  irq_o;

   modport master (output address_i, we_i, data_i, input data_o, irq_o);
   modport slave  (input address_i, we_i, data_i, output data_o, irq_o);
endinterface

// File: rtl/bus_timer_responder.sv
// Memory-mapped timer: CTRL/COMPARE/COUNT/STATUS window with an 8-bit prescaler,
// one-shot or auto-reload compare match, and a level interrupt.
module bus_timer_responder #(
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_9000,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   bus_timer_responder_if.slave bus
);
   localparam int unsigned PS_WIDTH = 8;
   localparam logic [1:0] OFF_CTRL    = 2'd0;
   localparam logic [1:0] OFF_COMPARE = 2'd1;
   localparam logic [1:0] OFF_COUNT   = 2'd2;
   localparam logic [1:0] OFF_STATUS  = 2'd3;
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDRESS);

   logic                  en_q, en_d;
   logic                  auto_q, auto_d;
   logic                  irq_en_q, irq_en_d;
   logic [PS_WIDTH-1:0]   prescale_q, prescale_d;
   logic [PS_WIDTH-1:0]   ps_q, ps_d;
   logic [DATA_WIDTH-1:0] compare_q, compare_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic                  match_q, match_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  irq_q, irq_d;

   logic                  hit;
   logic [1:0]            offset;
   logic                  wr_ctrl, wr_compare, wr_count, wr_status;
   logic                  tick, tick_eff;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic                  unused_low_addr;

   assign hit             = (bus.address_i[ADDR_WIDTH-1:4] == BASE[ADDR_WIDTH-1:4]);
   assign offset          = bus.address_i[3:2];
   assign unused_low_addr = ^bus.address_i[1:0];

   assign wr_ctrl    = bus.we_i && hit && (offset == OFF_CTRL);
   assign wr_compare = bus.we_i && hit && (offset == OFF_COMPARE);
   assign wr_count   = bus.we_i && hit && (offset == OFF_COUNT);
   assign wr_status  = bus.we_i && hit && (offset == OFF_STATUS);

   // A tick is dropped when the same edge writes COUNT or writes CTRL with EN=0.
   assign tick     = en_q && (ps_q == prescale_q);
   assign tick_eff = tick && !(wr_ctrl && !bus.data_i[0]) && !wr_count;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         en_q       <= 1'b0;
         auto_q     <= 1'b0;
         irq_en_q   <= 1'b0;
         prescale_q <= '0;
         ps_q       <= '0;
         compare_q  <= '0;
         count_q    <= '0;
         match_q    <= 1'b0;
         data_q     <= '0;
         irq_q      <= 1'b0;
      end else begin
         en_q       <= en_d;
         auto_q     <= auto_d;
         irq_en_q   <= irq_en_d;
         prescale_q <= prescale_d;
         ps_q       <= ps_d;
         compare_q  <= compare_d;
         count_q    <= count_d;
         match_q    <= match_d;
         data_q     <= data_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (offset)
         OFF_CTRL:    rd_mux = DATA_WIDTH'({prescale_q, 5'b0, irq_en_q, auto_q, en_q});
         OFF_COMPARE: rd_mux = compare_q;
         OFF_COUNT:   rd_mux = count_q;
         OFF_STATUS:  rd_mux = DATA_WIDTH'({en_q, match_q});
         default:     rd_mux = '0;
      endcase
   end

   // Timer update first, then bus writes override so the bus always wins.
   always_comb begin
      en_d       = en_q;
      auto_d     = auto_q;
      irq_en_d   = irq_en_q;
      prescale_d = prescale_q;
      ps_d       = ps_q;
      compare_d  = compare_q;
      count_d    = count_q;
      match_d    = match_q;

      if (en_q) begin
         ps_d = tick ? '0 : PS_WIDTH'(ps_q + 1'b1);
      end

      // W1C is applied before the match set so a same-edge match keeps MATCH high.
      if (wr_status && bus.data_i[0]) begin
         match_d = 1'b0;
      end

      if (tick_eff) begin
         if (count_q == compare_q) begin
            match_d = 1'b1;
            if (auto_q) begin
               count_d = '0;
            end else begin
               en_d = 1'b0;
            end
         end else begin
            count_d = DATA_WIDTH'(count_q + 1'b1);
         end
      end

      if (wr_ctrl) begin
         en_d       = bus.data_i[0];
         auto_d     = bus.data_i[1];
         irq_en_d   = bus.data_i[2];
         prescale_d = bus.data_i[15:8];
      end
      if (wr_compare) begin
         compare_d = bus.data_i;
      end
      if (wr_count) begin
         count_d = bus.data_i;
         ps_d    = '0;
      end
      if ((wr_ctrl && bus.data_i[0] && !en_q) || !en_d) begin
         ps_d = '0;
      end

      irq_d  = match_d && irq_en_d;
      data_d = (hit && !bus.we_i) ? rd_mux : '0;
   end

   assign bus.data_o = data_q;
   assign bus.irq_o  = irq_q;
endmodule

// File: tb/tb_bus_timer_responder.sv
// Self-checking bench for bus_timer_responder: read expectations are queued when
// a bus cycle is driven and compared against data_o on the following cycle.
module tb_bus_timer_responder;
   localparam logic [31:0] A_CTRL = 32'h0000_9000;
   localparam logic [31:0] A_CMP  = 32'h0000_9004;
   localparam logic [31:0] A_CNT  = 32'h0000_9008;
   localparam logic [31:0] A_STS  = 32'h0000_900C;
   localparam logic [31:0] A_MISS = 32'h0000_9010;
   localparam logic [31:0] A_IDLE = 32'h0000_0000;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   bus_timer_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

   bus_timer_responder #(
      .BASE_ADDRESS(32'h0000_9000),
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32)
   ) dut (
      .clk_i  (clk),
      .reset_i(rst_n),
      .bus    (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
   endtask

   // Pops last cycle's expectation, then drives this cycle and queues its expectation.
   task automatic bus_cycle(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic [31:0] rexp, input string tag);
      @(negedge clk);
      if (exp_q.size() > 0) check_eq(tag_q.pop_front(), bif.data_o, exp_q.pop_front());
      bif.address_i = addr;
      bif.we_i      = we;
      bif.data_i    = wdata;
      exp_q.push_back(we ? 32'h0 : rexp);
      tag_q.push_back(tag);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      bus_cycle(addr, 1'b0, 32'h0, exp, tag);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
      bus_cycle(addr, 1'b1, wdata, 32'h0, "wr_data_o");
   endtask

   task automatic idle();
      bus_cycle(A_IDLE, 1'b0, 32'h0, 32'h0, "idle");
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bif.address_i = '0;
      bif.we_i      = 1'b0;
      bif.data_i    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_eq("rst_irq", 32'(bif.irq_o), 32'h0);
      check_eq("rst_data", bif.data_o, 32'h0);
      rd(A_CTRL, 32'h0, "rst_ctrl");
      rd(A_CMP,  32'h0, "rst_compare");
      rd(A_CNT,  32'h0, "rst_count");
      rd(A_STS,  32'h0, "rst_status");

      // Decode, read latency, write-cycle zero and CTRL bit masking.
      wr(A_CMP, 32'h1234);
      rd(A_CMP, 32'h1234, "compare_rd");
      rd(A_MISS, 32'h0, "miss_rd");
      rd(32'h0000_9007, 32'h1234, "low_addr_ignored");
      wr(A_CTRL, 32'hFFFF_FF06);
      rd(A_CTRL, 32'h0000_FF06, "ctrl_mask");
      wr(A_CTRL, 32'h0);

      // One-shot match with IRQ.
      wr(A_CMP, 32'd5);
      wr(A_CNT, 32'd0);
      wr(A_CTRL, 32'h05);
      for (int j = 1; j <= 7; j++) begin
         if (j < 7) rd(A_CNT, 32'(j - 1), $sformatf("os_count%0d", j));
         else       rd(A_STS, 32'h1, "os_status_match");
         check_eq($sformatf("os_irq%0d", j), 32'(bif.irq_o), 32'(j == 7));
      end
      rd(A_CTRL, 32'h04, "os_ctrl_en_cleared");
      rd(A_CNT, 32'd5, "os_count_hold");
      wr(A_STS, 32'h1);
      check_eq("os_irq_before_clr", 32'(bif.irq_o), 32'h1);
      idle();
      check_eq("os_irq_after_clr", 32'(bif.irq_o), 32'h0);
      rd(A_STS, 32'h0, "os_status_cleared");

      // Auto-reload with PRESCALE=3: tick every 4 cycles, match every 12.
      wr(A_CTRL, 32'h0);
      wr(A_CNT, 32'h0);
      wr(A_STS, 32'h1);
      wr(A_CMP, 32'd2);
      wr(A_CTRL, 32'h0303);
      for (int j = 1; j <= 13; j++) begin
         rd(A_CNT, 32'(((j - 1) / 4) % 3), $sformatf("ar_count%0d", j));
         check_eq("ar_irq", 32'(bif.irq_o), 32'h0);
      end
      rd(A_STS, 32'h3, "ar_match1");
      wr(A_STS, 32'h1);
      rd(A_STS, 32'h2, "ar_match_cleared");
      repeat (7) idle();
      wr(A_STS, 32'h1);
      rd(A_STS, 32'h3, "w1c_vs_match_set_wins");
      idle();
      idle();
      wr(A_CNT, 32'h10);
      for (int j = 0; j < 4; j++) rd(A_CNT, 32'h10, "count_write_on_tick");
      rd(A_CNT, 32'h11, "count_after_next_tick");
      check_eq("ar_irq_end", 32'(bif.irq_o), 32'h0);
      wr(A_CTRL, 32'h0);

      // Wrap-around from all-ones.
      wr(A_STS, 32'h1);
      wr(A_CNT, 32'hFFFF_FFFF);
      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'h01);
      for (int j = 1; j <= 5; j++)
         rd(A_CNT, (j == 1) ? 32'hFFFF_FFFF : 32'(j - 2), $sformatf("wrap_count%0d", j));
      rd(A_STS, 32'h1, "wrap_match");
      rd(A_CNT, 32'd3, "wrap_count_hold");

      // Asynchronous reset in the middle of counting.
      wr(A_CMP, 32'd100);
      wr(A_STS, 32'h1);
      wr(A_CNT, 32'h0);
      wr(A_CTRL, 32'h05);
      repeat (5) idle();
      #2 rst_n = 1'b0;
      exp_q.delete();
      tag_q.delete();
      #1;
      check_eq("midrst_data", bif.data_o, 32'h0);
      check_eq("midrst_irq", 32'(bif.irq_o), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd(A_CTRL, 32'h0, "midrst_ctrl");
      rd(A_CMP,  32'h0, "midrst_compare");
      rd(A_CNT,  32'h0, "midrst_count");
      rd(A_STS,  32'h0, "midrst_status");
      rd(A_CNT,  32'h0, "midrst_no_count");
      check_eq("midrst_irq_after", 32'(bif.irq_o), 32'h0);

      @(negedge clk);
      while (exp_q.size() > 0) check_eq(tag_q.pop_front(), bif.data_o, exp_q.pop_front());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
